accel_tilt_seq: RTL and testbench
=================================

Name: accel_tilt_seq

Overview:
- Sequencer directly upstream of the CORDIC vectoring unit.
- Latches one accelerometer sample (ax, ay, az) and issues two chained CORDIC requests:
  - roll = atan2(ay, az)
  - pitch = atan2(-ax, sqrt(ay²+az²))
- The roll magnitude result is the pitch x-input.
- Delivers both tilt angles with a valid pulse to the attitude filter.

Parameters:
- ACC_W, 16, signed accelerometer sample width.
- CRD_W, 24, CORDIC operand/result width.
- TIMEOUT, 64, maximum cycles waited for crd_done per request.
- TILT_LIMIT, 5240, absolute angle fault threshold (131 LSB/deg; 5240 ≈ 40°).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- acc_x / acc_y / acc_z  in  ACC_W each  signed sample
- acc_valid  in  1  one-cycle sample strobe
- crd_x / crd_y  out  CRD_W each  signed CORDIC operands
- crd_start  out  1  one-cycle CORDIC request pulse
- crd_done  in  1  CORDIC completion pulse
- crd_angle  in  CRD_W  signed angle, 11790 = 90°
- crd_magnitude  in  CRD_W  gain-compensated magnitude
- roll / pitch  out  16 each  signed tilt angles, 131 LSB/deg
- tilt_valid  out  1  one-cycle result strobe
- busy  out  1  high from sample accept to completion or abort
- crd_err  out  1  one-cycle timeout pulse
- overrun_cnt  out  8  saturating count of dropped samples
- tilt_fault  out  1  limit flag (see Optional Feature)

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
  - All outputs and registers go to 0; FSM enters IDLE.
  - Reset mid-operation abandons the sequence. No tilt_valid and no crd_err are produced for it.
- States: IDLE, ROLL_WAIT, PITCH_WAIT.
- IDLE: on acc_valid:
  - Latch the sample.
  - Drive crd_x = sign-extended acc_z and crd_y = sign-extended acc_y.
  - Pulse crd_start for exactly one cycle (registered).
  - Clear the timer; go to ROLL_WAIT.
- ROLL_WAIT: on crd_done:
  - Store roll = crd_angle[15:0].
  - Drive crd_x = crd_magnitude and crd_y = −sext(acc_x). Negate after sign-extension to CRD_W, so −32768 maps to +32768.
  - Pulse crd_start; go to PITCH_WAIT.
- PITCH_WAIT: on crd_done:
  - Register pitch = crd_angle[15:0].
  - Pulse tilt_valid; go to IDLE.
- crd_x/crd_y stay stable from the crd_start cycle until crd_done.
- roll/pitch hold their last values between strobes.
- Timer: counts cycles in each WAIT state. On reaching TIMEOUT with no crd_done:
  - Pulse crd_err; go to IDLE.
  - Roll/pitch are not updated.
  - A crd_done arriving later while in IDLE is ignored.
- Overrun: acc_valid while busy (including the cycle crd_done is sampled in PITCH_WAIT) is dropped. overrun_cnt increments, saturating at 255.
- Latency with a 14-iteration CORDIC, measured from the acc_valid sampling edge:
  - Normal case: tilt_valid visible 36 cycles later, i.e. 2×(ITERATIONS+4).
  - Zero-vector fast path on both requests: 4 cycles.
- Range: the CORDIC folds x<0, so roll is always within ±11790. An inverted airframe (az<0) reports the folded angle. This is a documented limitation, not an error.
- busy = (state != IDLE).

Optional Feature:
- Macro: ACCEL_TILT_FAULT_EN.
- Defined:
  - tilt_fault is registered together with tilt_valid.
  - Value = (|roll| > TILT_LIMIT) or (|pitch| > TILT_LIMIT).
  - Held until the next tilt_valid; cleared by reset.
- Undefined: tilt_fault is tied to 0 and no comparators are built.

Decomposition:
- Package tilt_pkg:
  - ACC_W, CRD_W.
  - ANGLE_90 = 11790, LSB_PER_DEG = 131.
  - FSM state enum (2-bit).
- One natural sub-module, crd_req_timer:
  - Clearable cycle counter with TIMEOUT compare.
  - Outputs an expired pulse.

Test Plan (bench uses the real CORDIC, ITERATIONS=14):
- ax=0, ay=0, az=16384 → roll=0, pitch=0 (±2 LSB); tilt_valid 36 cycles after acc_valid; busy high throughout; crd_start pulsed exactly twice.
- ax=0, ay=16384, az=16384 → roll≈5895 (±3), pitch≈0 (±2).
- ax=−16384, ay=0, az=16384 → roll≈0, pitch≈+5895 (±3). Repeat with ax=+16384 → pitch≈−5895.
- All-zero sample → roll=0, pitch=0, tilt_valid 4 cycles after acc_valid.
- CORDIC stub that never asserts crd_done → crd_err pulses at TIMEOUT cycles into ROLL_WAIT, busy drops, no tilt_valid. A following valid sample with the real CORDIC completes normally.
- Second acc_valid 10 cycles after the first → overrun_cnt=1 and outputs reflect the first sample only. Then assert rst_n low at cycle 20 of a new sequence → all outputs 0, no tilt_valid. With ACCEL_TILT_FAULT_EN, ay=az=16384 sets tilt_fault=1 (45° > 40°).

Source files
------------

// File: rtl/tilt_pkg.sv
// Shared widths, angle scaling and FSM encoding for the accelerometer tilt sequencer.
package tilt_pkg;

  localparam int ACC_W       = 16;
  localparam int CRD_W       = 24;
  localparam int ANGLE_90    = 11790;
  localparam int LSB_PER_DEG = 131;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ROLL_WAIT  = 2'd1,
    ST_PITCH_WAIT = 2'd2
  } tilt_state_e;

endpackage

// File: rtl/crd_req_timer.sv
// Per-request watchdog: counts cycles while a CORDIC request is outstanding and
// flags expiry when the TIMEOUT-th cycle passes with no completion.
module crd_req_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The owner leaves the wait state on this pulse, so the count never needs to wrap.
  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/accel_tilt_seq.sv
// Accelerometer tilt sequencer: chains roll = atan2(ay,az) and
// pitch = atan2(-ax, |(ay,az)|) through one CORDIC vectoring unit.
// Build option ACCEL_TILT_FAULT_EN adds the registered tilt_fault limit flag.
module accel_tilt_seq #(
  parameter int ACC_W      = tilt_pkg::ACC_W,
  parameter int CRD_W      = tilt_pkg::CRD_W,
  parameter int TIMEOUT    = 64,
  parameter int TILT_LIMIT = 5240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] acc_x,
  input  logic [ACC_W-1:0] acc_y,
  input  logic [ACC_W-1:0] acc_z,
  input  logic             acc_valid,
  output logic [CRD_W-1:0] crd_x,
  output logic [CRD_W-1:0] crd_y,
  output logic             crd_start,
  input  logic             crd_done,
  input  logic [CRD_W-1:0] crd_angle,
  input  logic [CRD_W-1:0] crd_magnitude,
  output logic [15:0]      roll,
  output logic [15:0]      pitch,
  output logic             tilt_valid,
  output logic             busy,
  output logic             crd_err,
  output logic [7:0]       overrun_cnt,
  output logic             tilt_fault
);

  import tilt_pkg::*;

  tilt_state_e      state_q, state_d;
  logic [ACC_W-1:0] ax_q, ax_d;
  logic [CRD_W-1:0] crd_x_q, crd_x_d;
  logic [CRD_W-1:0] crd_y_q, crd_y_d;
  logic             crd_start_q, crd_start_d;
  logic [15:0]      roll_q, roll_d;
  logic [15:0]      pitch_q, pitch_d;
  logic             tilt_valid_q, tilt_valid_d;
  logic             crd_err_q, crd_err_d;
  logic [7:0]       ovr_q, ovr_d;

  logic             tmr_clr, tmr_en, tmr_expired;
  logic [CRD_W-1:0] ay_ext, az_ext, ax_ext;
  logic [15:0]      angle_lo;
  logic             unused_angle_hi;

  assign ay_ext   = {{(CRD_W-ACC_W){acc_y[ACC_W-1]}}, acc_y};
  assign az_ext   = {{(CRD_W-ACC_W){acc_z[ACC_W-1]}}, acc_z};
  assign ax_ext   = {{(CRD_W-ACC_W){ax_q[ACC_W-1]}}, ax_q};
  assign angle_lo = crd_angle[15:0];
  // Angles never exceed +/-11790, so the upper result bits carry no information.
  assign unused_angle_hi = ^crd_angle[CRD_W-1:16];

  assign tmr_en = (state_q != ST_IDLE);

  crd_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    ax_d         = ax_q;
    crd_x_d      = crd_x_q;
    crd_y_d      = crd_y_q;
    crd_start_d  = 1'b0;
    roll_d       = roll_q;
    pitch_d      = pitch_q;
    tilt_valid_d = 1'b0;
    crd_err_d    = 1'b0;
    ovr_d        = ovr_q;
    tmr_clr      = 1'b0;

    // A sample arriving while any request is outstanding is dropped and counted.
    if (acc_valid && state_q != ST_IDLE && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (acc_valid) begin
          ax_d        = acc_x;
          crd_x_d     = az_ext;
          crd_y_d     = ay_ext;
          crd_start_d = 1'b1;
          tmr_clr     = 1'b1;
          state_d     = ST_ROLL_WAIT;
        end
      end
      ST_ROLL_WAIT: begin
        if (crd_done) begin
          roll_d      = angle_lo;
          crd_x_d     = crd_magnitude;
          // Negating at full CRD_W keeps -32768 representable as +32768.
          crd_y_d     = -ax_ext;
          crd_start_d = 1'b1;
          tmr_clr     = 1'b1;
          state_d     = ST_PITCH_WAIT;
        end else if (tmr_expired) begin
          crd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_PITCH_WAIT: begin
        if (crd_done) begin
          pitch_d      = angle_lo;
          tilt_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (tmr_expired) begin
          crd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ax_q         <= '0;
      crd_x_q      <= '0;
      crd_y_q      <= '0;
      crd_start_q  <= 1'b0;
      roll_q       <= '0;
      pitch_q      <= '0;
      tilt_valid_q <= 1'b0;
      crd_err_q    <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      ax_q         <= ax_d;
      crd_x_q      <= crd_x_d;
      crd_y_q      <= crd_y_d;
      crd_start_q  <= crd_start_d;
      roll_q       <= roll_d;
      pitch_q      <= pitch_d;
      tilt_valid_q <= tilt_valid_d;
      crd_err_q    <= crd_err_d;
      ovr_q        <= ovr_d;
    end
  end

`ifdef ACCEL_TILT_FAULT_EN
  logic fault_q, fault_d;

  function automatic logic over_limit(input logic signed [15:0] a);
    return (a > TILT_LIMIT) || (a < -TILT_LIMIT);
  endfunction

  // Evaluated against the stored roll and the incoming pitch so it lands with tilt_valid.
  always_comb begin
    fault_d = fault_q;
    if (state_q == ST_PITCH_WAIT && crd_done)
      fault_d = over_limit(roll_q) || over_limit(angle_lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign tilt_fault = fault_q;
`else
  assign tilt_fault = 1'b0;
`endif

  assign crd_x       = crd_x_q;
  assign crd_y       = crd_y_q;
  assign crd_start   = crd_start_q;
  assign roll        = roll_q;
  assign pitch       = pitch_q;
  assign tilt_valid  = tilt_valid_q;
  assign crd_err     = crd_err_q;
  assign overrun_cnt = ovr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_accel_tilt_seq.sv
// Directed bench for accel_tilt_seq against a behavioural 14-iteration CORDIC
// vectoring model (zero-vector fast path, x folding, 16-cycle normal latency).
module tb_accel_tilt_seq;

  localparam int ITER = 14;
`ifdef ACCEL_TILT_FAULT_EN
  localparam int FAULT_ON = 1;
`else
  localparam int FAULT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] acc_x = '0, acc_y = '0, acc_z = '0;
  logic        acc_valid = 1'b0;
  logic [23:0] crd_x, crd_y, crd_angle, crd_magnitude;
  logic        crd_start, crd_done;
  logic [15:0] roll, pitch;
  logic        tilt_valid, busy, crd_err, tilt_fault;
  logic [7:0]  overrun_cnt;

  logic mdl_done = 1'b0;
  logic inj_done = 1'b0;
  int   mdl_cnt = 0;
  bit   stub_dead = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign crd_done = mdl_done | inj_done;

  accel_tilt_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .acc_x         (acc_x),
    .acc_y         (acc_y),
    .acc_z         (acc_z),
    .acc_valid     (acc_valid),
    .crd_x         (crd_x),
    .crd_y         (crd_y),
    .crd_start     (crd_start),
    .crd_done      (crd_done),
    .crd_angle     (crd_angle),
    .crd_magnitude (crd_magnitude),
    .roll          (roll),
    .pitch         (pitch),
    .tilt_valid    (tilt_valid),
    .busy          (busy),
    .crd_err       (crd_err),
    .overrun_cnt   (overrun_cnt),
    .tilt_fault    (tilt_fault)
  );

  function automatic int rnd(input real v);
    return $rtoi(v < 0.0 ? v - 0.5 : v + 0.5);
  endfunction

  function automatic int f_ang(input logic [23:0] x, input logic [23:0] y);
    real xr, yr;
    xr = real'($signed(x));
    yr = real'($signed(y));
    if (xr < 0.0) xr = -xr;
    return rnd($atan2(yr, xr) * 2.0 * 11790.0 / 3.141592653589793);
  endfunction

  function automatic int f_mag(input logic [23:0] x, input logic [23:0] y);
    real xr, yr;
    xr = real'($signed(x));
    yr = real'($signed(y));
    return rnd($sqrt(xr * xr + yr * yr));
  endfunction

  // CORDIC model: done 16 edges after it samples crd_start, or at once for (0,0).
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (crd_start && !stub_dead) begin
      crd_angle     <= 24'(f_ang(crd_x, crd_y));
      crd_magnitude <= 24'(f_mag(crd_x, crd_y));
      if (crd_x == '0 && crd_y == '0) begin
        mdl_done <= 1'b1;
        mdl_cnt  <= 0;
      end else begin
        mdl_cnt <= ITER + 2;
      end
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input int obs, input int want, input int tol);
    n_chk++;
    if (obs > want + tol || obs < want - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, want, tol);
    end
  endtask

  // Issue one sample and follow it until tilt_valid (bounded at 200 cycles).
  task automatic run(input int ax, input int ay, input int az,
                     output int lat, output int starts, output int x1, output int y2,
                     output bit busy_ok, output bit err_seen);
    @(negedge clk);
    acc_x = 16'(ax); acc_y = 16'(ay); acc_z = 16'(az); acc_valid = 1'b1;
    @(posedge clk); #1 acc_valid = 1'b0;
    lat = 0; starts = 0; x1 = 0; y2 = 0; busy_ok = 1'b1; err_seen = 1'b0;
    while (!tilt_valid && lat < 200) begin
      if (crd_start) begin
        if (starts == 0) x1 = int'($signed(crd_x));
        if (starts == 1) y2 = int'($signed(crd_y));
        starts++;
      end
      if (!busy) busy_ok = 1'b0;
      if (crd_err) err_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, st, x1, y2;
    bit bok, err, tv;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_roll", int'(roll), 0, 0);
    chk("rst_pitch", int'(pitch), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_start", int'(crd_start), 0, 0);
    chk("rst_ovr", int'(overrun_cnt), 0, 0);
    chk("rst_fault", int'(tilt_fault), 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // level attitude
    run(0, 0, 16384, lat, st, x1, y2, bok, err);
    chk("lvl_lat", lat, 36, 0);
    chk("lvl_starts", st, 2, 0);
    chk("lvl_busy", int'(bok), 1, 0);
    chk("lvl_x1", x1, 16384, 0);
    chk("lvl_err", int'(err), 0, 0);
    chk("lvl_roll", int'($signed(roll)), 0, 2);
    chk("lvl_pitch", int'($signed(pitch)), 0, 2);
    chk("lvl_fault", int'(tilt_fault), 0, 0);
    @(posedge clk); #1;
    chk("lvl_tv_pulse", int'(tilt_valid), 0, 0);
    chk("lvl_idle", int'(busy), 0, 0);

    // 45 degree roll
    run(0, 16384, 16384, lat, st, x1, y2, bok, err);
    chk("r45_lat", lat, 36, 0);
    chk("r45_roll", int'($signed(roll)), 5895, 3);
    chk("r45_pitch", int'($signed(pitch)), 0, 2);
    chk("r45_fault", int'(tilt_fault), FAULT_ON, 0);

    // nose up / nose down
    run(-16384, 0, 16384, lat, st, x1, y2, bok, err);
    chk("pup_y2", y2, 16384, 0);
    chk("pup_roll", int'($signed(roll)), 0, 2);
    chk("pup_pitch", int'($signed(pitch)), 5895, 3);
    run(16384, 0, 16384, lat, st, x1, y2, bok, err);
    chk("pdn_y2", y2, -16384, 0);
    chk("pdn_pitch", int'($signed(pitch)), -5895, 3);

    // zero vector on both requests
    run(0, 0, 0, lat, st, x1, y2, bok, err);
    chk("zero_lat", lat, 4, 0);
    chk("zero_starts", st, 2, 0);
    chk("zero_roll", int'($signed(roll)), 0, 0);
    chk("zero_pitch", int'($signed(pitch)), 0, 0);

    // most-negative ax: fast roll, -(-32768) must reach CORDIC as +32768
    run(-32768, 0, 0, lat, st, x1, y2, bok, err);
    chk("neg_lat", lat, 20, 0);
    chk("neg_y2", y2, 32768, 0);
    chk("neg_pitch", int'($signed(pitch)), 11790, 2);

    // dead CORDIC: timeout in ROLL_WAIT
    stub_dead = 1'b1;
    @(negedge clk);
    acc_x = 16'd0; acc_y = 16'd16384; acc_z = 16'd16384; acc_valid = 1'b1;
    @(posedge clk); #1 acc_valid = 1'b0;
    lat = 0; tv = 1'b0;
    while (!crd_err && lat < 200) begin
      if (tilt_valid) tv = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("to_lat", lat, 64, 0);
    chk("to_busy", int'(busy), 0, 0);
    chk("to_tv", int'(tv), 0, 0);
    @(posedge clk); #1;
    chk("to_err_pulse", int'(crd_err), 0, 0);
    stub_dead = 1'b0;
    @(negedge clk) inj_done = 1'b1;
    @(negedge clk) inj_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (tilt_valid || busy || crd_start) tv = 1'b1;
    end
    chk("late_done", int'(tv), 0, 0);
    chk("to_roll_hold", int'($signed(roll)), 0, 0);
    chk("to_pitch_hold", int'($signed(pitch)), 11790, 2);

    // recovery with a live CORDIC
    run(0, -16384, 16384, lat, st, x1, y2, bok, err);
    chk("rec_lat", lat, 36, 0);
    chk("rec_roll", int'($signed(roll)), -5895, 3);
    chk("rec_pitch", int'($signed(pitch)), 0, 2);

    // overrun: second strobe 10 cycles after the first is dropped
    @(negedge clk);
    acc_x = -16'sd16384; acc_y = 16'd16384; acc_z = 16'd16384; acc_valid = 1'b1;
    @(posedge clk); #1 acc_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    acc_x = 16'd0; acc_y = 16'd0; acc_z = 16'd16384; acc_valid = 1'b1;
    @(posedge clk); #1 acc_valid = 1'b0;
    lat = 10;
    while (!tilt_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ovr_lat", lat, 36, 0);
    chk("ovr_cnt", int'(overrun_cnt), 1, 0);
    chk("ovr_roll", int'($signed(roll)), 5895, 3);
    chk("ovr_pitch", int'($signed(pitch)), 4620, 3);

    // reset 20 cycles into a sequence
    @(negedge clk);
    acc_x = 16'd0; acc_y = 16'd16384; acc_z = 16'd16384; acc_valid = 1'b1;
    @(posedge clk); #1 acc_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_roll", int'(roll), 0, 0);
    chk("mid_pitch", int'(pitch), 0, 0);
    chk("mid_busy", int'(busy), 0, 0);
    chk("mid_crd_x", int'(crd_x), 0, 0);
    chk("mid_crd_y", int'(crd_y), 0, 0);
    chk("mid_ovr", int'(overrun_cnt), 0, 0);
    chk("mid_fault", int'(tilt_fault), 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tv = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (tilt_valid || crd_err || busy) tv = 1'b1;
    end
    chk("mid_quiet", int'(tv), 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
